// File: rtl/rca_seq.sv
// rca_seq: multi-limb adder that pushes one word_width limb per clock through a single RCA_M.
// Define RCA_SEQ_SUB_EN to add the SUB port, which selects A-B instead of A+B+C_IN.

module RCA_M #(
    parameter int word_width = 8
) (
    input  logic [word_width-1:0] A,
    input  logic [word_width-1:0] B,
    input  logic                  C_IN,
    output logic [word_width-1:0] R,
    output logic                  C_OUT
);
    logic [word_width:0] c;

    always_comb begin
        c    = '0;
        R    = '0;
        c[0] = C_IN;
        for (int i = 0; i < word_width; i++) begin
            R[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign C_OUT = c[word_width];
endmodule

// Handshake: an input transfer happens on a rising CLK edge where IN_VALID && IN_READY;
// an output transfer happens on a rising edge where OUT_VALID && OUT_READY. Results stay
// stable while OUT_VALID is high and OUT_READY is low.
module rca_seq #(
    parameter int word_width = 8,
    parameter int word_count = 4
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [word_width*word_count-1:0] A,
    input  logic [word_width*word_count-1:0] B,
    input  logic                             C_IN,
`ifdef RCA_SEQ_SUB_EN
    input  logic                             SUB,
`endif
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [word_width*word_count-1:0] R,
    output logic                             C_OUT,
    output logic                             BUSY
);
    localparam int N  = word_width * word_count;
    localparam int IW = $clog2(word_count);
    localparam logic [IW-1:0] LAST = IW'(word_count - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    r_q, r_d;
    logic            carry_q, carry_d;
    logic            c_out_q, c_out_d;

    logic [N-1:0]          cap_b;
    logic                  cap_c;
    logic [word_width-1:0] limb_a, limb_b, limb_r;
    logic                  limb_c;

    // Subtraction is A + ~B + 1, so it reuses the same adder with a forced carry-in.
`ifdef RCA_SEQ_SUB_EN
    assign cap_b = SUB ? ~B : B;
    assign cap_c = SUB ? 1'b1 : C_IN;
`else
    assign cap_b = B;
    assign cap_c = C_IN;
`endif

    assign limb_a = a_q[idx_q*word_width +: word_width];
    assign limb_b = b_q[idx_q*word_width +: word_width];

    RCA_M #(word_width) u_rca (
        .A     (limb_a),
        .B     (limb_b),
        .C_IN  (carry_q),
        .R     (limb_r),
        .C_OUT (limb_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = cap_b;
                    carry_d = cap_c;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d[idx_q*word_width +: word_width] = limb_r;
                carry_d = limb_c;
                if (idx_q == LAST) begin
                    c_out_d = limb_c;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q == RUN);
    assign R         = r_q;
    assign C_OUT     = c_out_q;
endmodule

// File: tb/tb_rca_seq.sv
// Self-checking bench for rca_seq (word_width=4, word_count=4): vector table, corner sequences, random run.
// Subtract checks are compiled in when RCA_SEQ_SUB_EN is defined.

module tb_rca_seq;
    localparam int WW = 4;
    localparam int WC = 4;
    localparam int N  = WW * WC;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         C_IN = 1'b0;
    logic         SUB = 1'b0;
    logic         OUT_READY = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         IN_READY, OUT_VALID, C_OUT, BUSY;
    logic [N-1:0] R;

    always #5 CLK = ~CLK;

    rca_seq #(.word_width(WW), .word_count(WC)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .C_IN      (C_IN),
`ifdef RCA_SEQ_SUB_EN
        .SUB       (SUB),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .R         (R),
        .C_OUT     (C_OUT),
        .BUSY      (BUSY)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        logic [N-1:0] r;
        logic         c;
    } vec_t;

    vec_t       vecs[$];
    logic [N:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random stalls
    int         cyc = 0;
    int         acc_cyc = 0;

    always @(posedge CLK) cyc++;

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       OUT_READY = 1'b0;
            1:       OUT_READY = 1'b1;
            default: OUT_READY = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: compare whenever a result is handed over.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) check("unexpected_result", {C_OUT, R}, '1);
            else check("result", {C_OUT, R}, exp_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sub, input logic [N:0] exp, input bit push);
        int budget;
        A = a; B = b; C_IN = cin; SUB = sub; IN_VALID = 1'b1;
        budget = 0;
        @(negedge CLK);
        while (!IN_READY && budget < 200) begin
            budget++;
            @(negedge CLK);
        end
        if (!IN_READY) check("accept_timeout", {16'h0, IN_READY}, 1);
        else begin
            acc_cyc = cyc;
            if (push) exp_q.push_back(exp);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = N'($urandom); B = N'($urandom);
        C_IN = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            budget++;
            @(negedge CLK);
        end
        check("drain_timeout", {16'h0, exp_q.size() == 0}, 1);
        @(posedge CLK); #1;
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
        logic [N:0] d;
        if (sub) begin
            d = {1'b0, a} - {1'b0, b};
            return {~d[N], d[N-1:0]};
        end
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int a1;
        logic [N-1:0] ra, rb;
        logic rc, rs;

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0});
`ifdef RCA_SEQ_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0});
`endif

        // Reset
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", {16'h0, IN_READY}, 1);
        check("rst_out_valid", {16'h0, OUT_VALID}, 0);
        check("rst_busy", {16'h0, BUSY}, 0);
        check("rst_r", {1'b0, R}, 0);
        check("rst_c_out", {16'h0, C_OUT}, 0);
        @(posedge CLK); #1;

        // Latency: OUT_VALID rises exactly WC edges after the accept edge
        rdy_mode = 0;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000}, 1'b1);
        for (int k = 0; k <= WC; k++) begin
            @(negedge CLK);
            check("latency_out_valid", {16'h0, OUT_VALID}, {16'h0, k == WC});
            if (k < WC) check("busy_in_run", {16'h0, BUSY}, 1);
        end
        check("latency_result", {C_OUT, R}, {1'b1, 16'h0000});
        rdy_mode = 1;
        wait_drain();

        // Output held stable under backpressure
        rdy_mode = 0;
        send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 16'h5556}, 1'b1);
        budget = 0;
        while (!OUT_VALID && budget < 50) begin
            budget++;
            @(negedge CLK);
        end
        check("stall_reach_valid", {16'h0, OUT_VALID}, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            check("stall_out_valid", {16'h0, OUT_VALID}, 1);
            check("stall_r", {1'b0, R}, {1'b0, 16'h5556});
            check("stall_c_out", {16'h0, C_OUT}, 0);
            check("stall_in_ready", {16'h0, IN_READY}, 0);
        end
        rdy_mode = 1;
        wait_drain();

        // New operands presented during RUN must wait for IN_READY
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0, {1'b0, 16'h1010}, 1'b1);
        a1 = acc_cyc;
        send(16'hABCD, 16'h1111, 1'b1, 1'b0, {1'b0, 16'hBCDF}, 1'b1);
        check("accept_spacing", (N+1)'(acc_cyc - a1), (N+1)'(WC + 2));
        wait_drain();

        // Reset at limb 2 abandons the operation
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '0, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("abort_busy_before", {16'h0, BUSY}, 1);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("abort_in_ready", {16'h0, IN_READY}, 1);
        check("abort_out_valid", {16'h0, OUT_VALID}, 0);
        check("abort_busy", {16'h0, BUSY}, 0);
        check("abort_r", {1'b0, R}, 0);
        check("abort_c_out", {16'h0, C_OUT}, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("abort_no_valid", {16'h0, OUT_VALID}, 0);
        end
        @(posedge CLK); #1;

        // Vector table
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, {vecs[i].c, vecs[i].r}, 1'b1);
            wait_drain();
        end

        // Random operands with random OUT_READY stalls
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef RCA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end
        wait_drain();

        check("queue_empty", {16'h0, exp_q.size() == 0}, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
